// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multicycle sequencer:
// state encoding, next-PC selects and latched decode flags.
package mctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

    localparam logic [1:0] PCSEL_SEQ   = 2'd0;
    localparam logic [1:0] PCSEL_EXU   = 2'd1;
    localparam logic [1:0] PCSEL_MTVEC = 2'd2;
    localparam logic [1:0] PCSEL_MEPC  = 2'd3;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic pc_write;
        logic is_ecall;
        logic is_mret;
        logic is_csr;
    } dec_flags_t;

    // Traps outrank returns, which outrank taken control flow.
    function automatic logic [1:0] f_pc_sel(
        input dec_flags_t f,
        input logic       taken
    );
        logic [1:0] sel;
        sel = PCSEL_SEQ;
        if (f.is_ecall)
            sel = PCSEL_MTVEC;
        else if (f.is_mret)
            sel = PCSEL_MEPC;
        else if (f.pc_write && taken)
            sel = PCSEL_EXU;
        return sel;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Sequencer-facing bundle: IFU/IDU/EXU/LSU handshakes,
// write strobes, error flag, debug state and perf counters.
interface multicycle_ctrl_if;

    logic        ifu_req;
    logic        ifu_rvalid;
    logic        idu_valid;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_reg_write;
    logic        dec_pc_write;
    logic        dec_is_ecall;
    logic        dec_is_mret;
    logic        dec_is_csr;
    logic        exu_taken;
    logic        lsu_req;
    logic        lsu_wen;
    logic        lsu_rvalid;
    logic        rf_wen;
    logic        pc_wen;
    logic [1:0]  pc_sel;
    logic        csr_wen;
    logic        trap_ecall;
    logic        bus_err;
    logic [2:0]  state;
    logic [63:0] perf_cycles;
    logic [63:0] perf_instret;

    modport master (
        output ifu_req, idu_valid, lsu_req, lsu_wen,
        output rf_wen, pc_wen, pc_sel, csr_wen,
        output trap_ecall, bus_err, state,
        output perf_cycles, perf_instret,
        input  ifu_rvalid, lsu_rvalid, exu_taken,
        input  dec_mem_read, dec_mem_write,
        input  dec_reg_write, dec_pc_write,
        input  dec_is_ecall, dec_is_mret, dec_is_csr
    );

    modport slave (
        input  ifu_req, idu_valid, lsu_req, lsu_wen,
        input  rf_wen, pc_wen, pc_sel, csr_wen,
        input  trap_ecall, bus_err, state,
        input  perf_cycles, perf_instret,
        output ifu_rvalid, lsu_rvalid, exu_taken,
        output dec_mem_read, dec_mem_write,
        output dec_reg_write, dec_pc_write,
        output dec_is_ecall, dec_is_mret, dec_is_csr
    );

endinterface

// File: rtl/mctrl_wait_timer.sv
// Wait-cycle counter shared by FETCH and MEM; o_hit flags
// the last permitted wait cycle. TIMEOUT=0 never hits.
module mctrl_wait_timer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_hit
);

    logic [CNT_W-1:0] r_cnt;

    // Count waiting cycles; any state change restarts from zero.
    always_ff @(posedge clk) begin
        if (rst || i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + 1'b1;
    end

    generate
        if (TIMEOUT == 0) begin : g_off
            assign o_hit = 1'b0;
        end else begin : g_on
            assign o_hit = i_en &&
                (r_cnt == CNT_W'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle core sequencer: FETCH/DECODE/EXEC/MEM/WB/ERR.
// Define MCTRL_PERF_EN to build the cycle/instret counters.
module multicycle_ctrl
    import mctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);

    state_e     r_state;
    state_e     w_next;
    dec_flags_t r_flags;
    logic       r_taken;
    logic       w_hit;
    logic       w_clr;
    logic       w_en;
    logic       w_mem;

    assign w_mem = r_flags.mem_read | r_flags.mem_write;
    assign w_en  = (r_state == ST_FETCH) |
                   (r_state == ST_MEM);
    assign w_clr = (w_next != r_state);

    mctrl_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_clr),
        .i_en  (w_en),
        .o_hit (w_hit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= ST_FETCH;
        else
            r_state <= w_next;
    end

    // Capture decode flags in DECODE and branch outcome in EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= '0;
            r_taken <= 1'b0;
        end else begin
            if (r_state == ST_DECODE) begin
                r_flags.mem_read  <= bus.dec_mem_read;
                r_flags.mem_write <= bus.dec_mem_write;
                r_flags.reg_write <= bus.dec_reg_write;
                r_flags.pc_write  <= bus.dec_pc_write;
                r_flags.is_ecall  <= bus.dec_is_ecall;
                r_flags.is_mret   <= bus.dec_is_mret;
                r_flags.is_csr    <= bus.dec_is_csr;
            end
            if (r_state == ST_EXEC)
                r_taken <= bus.exu_taken;
        end
    end

    // Next state; a response beats a same-cycle timeout.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_FETCH: begin
                if (bus.ifu_rvalid)
                    w_next = ST_DECODE;
                else if (w_hit)
                    w_next = ST_ERR;
            end
            ST_DECODE: w_next = ST_EXEC;
            ST_EXEC:   w_next = w_mem ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (bus.lsu_rvalid)
                    w_next = ST_WB;
                else if (w_hit)
                    w_next = ST_ERR;
            end
            ST_WB:     w_next = ST_FETCH;
            ST_ERR:    w_next = ST_ERR;
            default:   w_next = ST_FETCH;
        endcase
    end

    // Moore outputs; WB strobes come from the latched flags.
    always_comb begin
        bus.ifu_req    = 1'b0;
        bus.idu_valid  = 1'b0;
        bus.lsu_req    = 1'b0;
        bus.lsu_wen    = 1'b0;
        bus.rf_wen     = 1'b0;
        bus.pc_wen     = 1'b0;
        bus.pc_sel     = PCSEL_SEQ;
        bus.csr_wen    = 1'b0;
        bus.trap_ecall = 1'b0;
        bus.bus_err    = 1'b0;
        unique case (r_state)
            ST_FETCH:  bus.ifu_req   = 1'b1;
            ST_DECODE: bus.idu_valid = 1'b1;
            ST_MEM: begin
                bus.lsu_req = 1'b1;
                bus.lsu_wen = r_flags.mem_write;
            end
            ST_WB: begin
                bus.pc_wen     = 1'b1;
                bus.rf_wen     = r_flags.reg_write &
                                 ~r_flags.is_ecall &
                                 ~r_flags.is_mret;
                bus.csr_wen    = r_flags.is_csr;
                bus.trap_ecall = r_flags.is_ecall;
                bus.pc_sel     = f_pc_sel(r_flags, r_taken);
            end
            ST_ERR:    bus.bus_err = 1'b1;
            default: ;
        endcase
    end

    assign bus.state = r_state;

`ifdef MCTRL_PERF_EN
    logic [63:0] r_cycles;
    logic [63:0] r_instret;

    // Cycle and retire counters, frozen while in ERR.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycles  <= '0;
            r_instret <= '0;
        end else if (r_state != ST_ERR) begin
            r_cycles <= r_cycles + 64'd1;
            if (r_state == ST_WB)
                r_instret <= r_instret + 64'd1;
        end
    end

    assign bus.perf_cycles  = r_cycles;
    assign bus.perf_instret = r_instret;
`else
    assign bus.perf_cycles  = 64'd0;
    assign bus.perf_instret = 64'd0;
`endif

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Central sequencer for the multicycle core. Steps each instruction through FETCH, DECODE, EXEC, optional MEM, and WB. Drives the fetch request to the IFU, the decode-valid strobe to the IDU, and the LSU request. Generates the register-file, PC and CSR write enables and the next-PC select from the latched decode flags.

Parameters:
TIMEOUT, 255, max wait cycles in FETCH or MEM before entering ERR; 0 disables the timeout
CNT_W, 8, width of the wait counter; must hold TIMEOUT

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
ifu_req  out  1  fetch request, held while in FETCH
ifu_rvalid  in  1  instruction word valid this cycle
idu_valid  out  1  one-cycle strobe in DECODE; IDU latches the instruction
dec_mem_read  in  1  decoded load
dec_mem_write  in  1  decoded store
dec_reg_write  in  1  decoded GPR write
dec_pc_write  in  1  decoded jump or branch
dec_is_ecall  in  1  decoded ecall
dec_is_mret  in  1  decoded mret
dec_is_csr  in  1  decoded CSR op
exu_taken  in  1  branch taken or jump, sampled in EXEC
lsu_req  out  1  memory request, held while in MEM
lsu_wen  out  1  store qualifier, valid with lsu_req
lsu_rvalid  in  1  LSU access complete
rf_wen  out  1  GPR write strobe (WB only)
pc_wen  out  1  PC update strobe (WB only)
pc_sel  out  2  0 pc+4, 1 exu target, 2 mtvec, 3 mepc
csr_wen  out  1  CSR write strobe (WB only)
trap_ecall  out  1  mepc/mcause update strobe (WB only)
bus_err  out  1  sticky timeout error
state  out  3  current state, for debug
perf_cycles  out  64  cycle counter (optional feature)
perf_instret  out  64  retired-instruction counter (optional feature)

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=5.
- Reset: state=FETCH, all strobes 0, bus_err=0, wait counter 0, latched flags 0.
- The first cycle after rst deasserts has ifu_req=1.
- FETCH: ifu_req=1. ifu_rvalid=1 -> DECODE. Otherwise the wait counter increments. When the counter reaches TIMEOUT, go to ERR.
- DECODE: idu_valid=1 for exactly one cycle. At the end of the cycle, all dec_* inputs are latched into internal flags -> EXEC.
- EXEC: one cycle; exu_taken is latched. If mem_read or mem_write is latched -> MEM, else -> WB.
- MEM: lsu_req=1 and lsu_wen=latched mem_write, both held until lsu_rvalid. lsu_rvalid=1 -> WB. The wait counter and timeout work as in FETCH.
- If mem_read and mem_write are both set, the access is treated as a store.
- WB: one cycle, then -> FETCH. Strobes:
  - pc_wen=1.
  - rf_wen = reg_write & !ecall & !mret.
  - csr_wen = is_csr.
  - trap_ecall = is_ecall.
- pc_sel priority: ecall=2, then mret=3, then (pc_write & taken)=1, else 0.
- Wait counter clears on every state change.
- If rvalid arrives on the same cycle the count reaches TIMEOUT, rvalid wins.
- ifu_rvalid or lsu_rvalid in any state other than its own is ignored.
- ERR: all strobes 0, bus_err=1. The state holds until rst.
- rst during any state: the next cycle is FETCH with outputs at reset values. Any outstanding response is ignored.
- Latency: 4 cycles per non-memory instruction when rvalid arrives in the first FETCH cycle; 5 cycles minimum for loads and stores.

Optional Feature:
MCTRL_PERF_EN
- Defined: perf_cycles increments every cycle after reset. perf_instret increments on each WB cycle. Both are 64-bit wrapping counters, cleared by rst. Neither counts while in ERR.
- Undefined: both ports are tied to 0 and no counter registers are built.

Decomposition:
- Package mctrl_pkg:
  - state enum, 3 bits, values as listed in Behaviour
  - pc_sel constants: PCSEL_SEQ=0, PCSEL_EXU=1, PCSEL_MTVEC=2, PCSEL_MEPC=3
- Sub-module mctrl_wait_timer: wait counter with clear, enable and timeout-hit output. Instantiated once and shared by FETCH and MEM.

Test Plan:
- ALU op, ifu_rvalid in first FETCH cycle, reg_write=1 -> states 0,1,2,4,0; rf_wen=1 and pc_wen=1 with pc_sel=0 in cycle 4.
- Load, lsu_rvalid 3 cycles after MEM entry -> lsu_req high for 3 cycles with lsu_wen=0, then WB with rf_wen=1; store -> lsu_wen=1 and rf_wen=0.
- Branch with pc_write=1: exu_taken=1 -> pc_sel=1; exu_taken=0 -> pc_sel=0; ecall -> pc_sel=2, trap_ecall=1, rf_wen=0; mret -> pc_sel=3.
- TIMEOUT=4, ifu_rvalid held 0 -> ERR after 4 FETCH cycles, bus_err=1 and sticky; ifu_rvalid on the 4th cycle instead -> DECODE and no error.
- rst asserted mid-MEM with lsu_rvalid pulsing next cycle -> state=FETCH, no WB strobes, response ignored; with MCTRL_PERF_EN, 10 ALU instructions -> perf_instret=10, perf_cycles=40.
